// File: rtl/univ_shift_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_n
// Brief    : WIDTH-bit universal shift register with an autonomous burst engine
// Revision : 1.0
// ============================================================================
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sir,
  input  logic             sil,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic             r_so_r, w_so_r_n;
  logic             r_so_l, w_so_l_n;
  logic             r_done, w_done_n;
  logic [2:0]       r_mode, w_mode_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;

  function automatic logic is_right(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

  function automatic logic is_left(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_ROL);
  endfunction

  function automatic logic [WIDTH-1:0] op_result(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             in_r,
    input logic             in_l
  );
    case (m)
      MODE_SHR:  return {in_r, cur[WIDTH-1:1]};
      MODE_SHL:  return {cur[WIDTH-2:0], in_l};
      MODE_LOAD: return ld;
      MODE_ROR:  return {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  return {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   return cur;
    endcase
  endfunction

  // Applies one operation of mode m to q and the serial-out flags.
  task automatic apply_op(input logic [2:0] m);
    w_q_n = op_result(m, r_q, load_data, sir, sil);
    if (is_right(m)) w_so_r_n = r_q[0];
    if (is_left(m))  w_so_l_n = r_q[WIDTH-1];
  endtask

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_so_r  <= 1'b0;
      r_so_l  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_so_r  <= w_so_r_n;
      r_so_l  <= w_so_l_n;
      r_done  <= w_done_n;
      r_mode  <= w_mode_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_so_r_n  = r_so_r;
    w_so_l_n  = r_so_l;
    w_done_n  = 1'b0;
    w_mode_n  = r_mode;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        // A burst request wins over the mode and ignores en; q holds this cycle.
        if (burst_start) begin
          if ((is_right(mode) || is_left(mode)) && (burst_cnt != '0)) begin
            w_state_n = RUN;
            w_mode_n  = mode;
            w_cnt_n   = burst_cnt;
          end else begin
            w_done_n = 1'b1;
          end
        end else if (en) begin
          apply_op(mode);
        end
      end
      RUN: begin
        if (en) begin
          apply_op(r_mode);
          if (r_cnt == CNT_W'(1)) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_done_n  = 1'b1;
          end else begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign q    = r_q;
  assign so_r = r_so_r;
  assign so_l = r_so_l;
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg_n
// Brief    : Directed plus randomized checks of univ_shift_reg_n against a model
// Revision : 1.0
// ============================================================================
module tb_univ_shift_reg_n;

  logic       clk = 1'b0;
  logic       rst, en, sir, sil, burst_start;
  logic [2:0] mode;
  logic [7:0] load_data;
  logic [3:0] burst_cnt;
  logic [7:0] q;
  logic       so_r, so_l, busy, done;

  int tests = 0;
  int fails = 0;

  // Reference state, derived from the operation rules with arithmetic.
  logic [7:0] m_q;
  logic       m_sor, m_sol, m_busy, m_done;
  int         m_left;
  logic [2:0] m_mode;

  univ_shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_data(load_data),
    .sir(sir), .sil(sil), .burst_start(burst_start), .burst_cnt(burst_cnt),
    .q(q), .so_r(so_r), .so_l(so_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [2:0] m);
    logic [7:0] old;
    old = m_q;
    case (m)
      3'd1: m_q = (old >> 1) | (sir ? 8'h80 : 8'h00);
      3'd2: m_q = ((old << 1) & 8'hFF) | (sil ? 8'h01 : 8'h00);
      3'd3: m_q = load_data;
      3'd4: m_q = (old >> 1) | ((old % 2 == 1) ? 8'h80 : 8'h00);
      3'd5: m_q = ((old << 1) & 8'hFF) | ((old >= 8'h80) ? 8'h01 : 8'h00);
      3'd6: m_q = (old >> 1) | (old & 8'h80);
      default: m_q = old;
    endcase
    if (m == 3'd1 || m == 3'd4 || m == 3'd6) m_sor = (old % 2 == 1);
    if (m == 3'd2 || m == 3'd5)              m_sol = (old >= 8'h80);
  endtask

  task automatic model_step();
    if (rst) begin
      m_q = 0; m_sor = 0; m_sol = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (burst_start) begin
          if (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6} && burst_cnt != 0) begin
            m_busy = 1; m_left = int'(burst_cnt); m_mode = mode;
          end else m_done = 1;
        end else if (en) model_apply(mode);
      end else if (en) begin
        model_apply(m_mode);
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] ld, input logic s_r, input logic s_l,
                     input logic b_s, input logic [3:0] b_c);
    rst = r; en = e; mode = m; load_data = ld; sir = s_r; sil = s_l;
    burst_start = b_s; burst_cnt = b_c;
    @(posedge clk);
    model_step();
    #1;
    chk("q", q, m_q);
    chk("so_r", 8'(so_r), 8'(m_sor));
    chk("so_l", 8'(so_l), 8'(m_sol));
    chk("busy", 8'(busy), 8'(m_busy));
    chk("done", 8'(done), 8'(m_done));
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] ld);
    cyc(0, 1, m, ld, 0, 0, 0, 0);
  endtask

  initial begin
    int busy_cycles;
    m_q = 0; m_sor = 0; m_sol = 0; m_busy = 0; m_done = 0; m_left = 0; m_mode = 0;

    cyc(1, 1, 3'd3, 8'h5A, 1, 1, 1, 4'd3);
    cyc(1, 0, 3'd5, 8'hFF, 0, 1, 0, 4'd7);
    chk("reset_q", q, 8'h00);
    chk("reset_busy", 8'(busy), 8'h00);

    op(3'd3, 8'hA5);                    chk("load_A5", q, 8'hA5);
    cyc(0, 1, 3'd1, 8'h00, 1, 0, 0, 0); chk("shr_D2", q, 8'hD2);
    chk("shr_so_r", 8'(so_r), 8'h01);
    cyc(0, 1, 3'd2, 8'h00, 0, 0, 0, 0); chk("shl_A4", q, 8'hA4);
    chk("shl_so_l", 8'(so_l), 8'h01);
    op(3'd3, 8'h81); op(3'd4, 0);       chk("ror_C0", q, 8'hC0);
    op(3'd3, 8'h81); op(3'd5, 0);       chk("rol_03", q, 8'h03);
    op(3'd3, 8'h80); op(3'd6, 0);       chk("asr_C0", q, 8'hC0);
    op(3'd7, 8'h55);                    chk("mode7_hold", q, 8'hC0);

    // Plain burst: rotate 0x0F left four times.
    op(3'd3, 8'h0F);
    busy_cycles = 0;
    cyc(0, 1, 3'd5, 8'h00, 0, 0, 1, 4'd4);
    for (int i = 0; i < 8 && busy; i++) begin
      busy_cycles++;
      cyc(0, 1, 3'd0, 8'h00, 0, 0, 0, 0);
    end
    chk("burst_busy_cycles", 8'(busy_cycles), 8'd4);
    chk("burst_q", q, 8'hF0);
    chk("burst_done", 8'(done), 8'h01);
    op(3'd0, 0);                        chk("burst_done_once", 8'(done), 8'h00);

    // Burst with a two-cycle stall and an ignored request during RUN.
    op(3'd3, 8'h0F);
    busy_cycles = 0;
    cyc(0, 1, 3'd5, 8'h00, 0, 0, 1, 4'd4);
    busy_cycles++; cyc(0, 1, 3'd3, 8'h33, 0, 0, 0, 0);
    busy_cycles++; cyc(0, 0, 3'd1, 8'h00, 0, 0, 1, 4'd9);
    busy_cycles++; cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 8 && busy; i++) begin
      busy_cycles++;
      cyc(0, 1, 3'd3, 8'h77, 0, 0, (i == 0), 4'd2);
    end
    chk("stall_busy_cycles", 8'(busy_cycles), 8'd6);
    chk("stall_q", q, 8'hF0);
    op(3'd0, 0);                        chk("stall_no_rerun", 8'(busy), 8'h00);

    // Degenerate requests.
    cyc(0, 1, 3'd5, 8'h00, 0, 0, 1, 4'd0);
    chk("cnt0_done", 8'(done), 8'h01);  chk("cnt0_q", q, 8'hF0);
    cyc(0, 0, 3'd3, 8'h12, 0, 0, 1, 4'd3);
    chk("load_burst_done", 8'(done), 8'h01); chk("load_burst_q", q, 8'hF0);

    // Reset in the middle of a burst.
    cyc(0, 1, 3'd1, 8'h00, 1, 0, 1, 4'd8);
    op(3'd0, 0); op(3'd0, 0);
    cyc(1, 1, 3'd0, 8'h00, 0, 0, 0, 0);
    chk("rst_run_q", q, 8'h00);         chk("rst_run_busy", 8'(busy), 8'h00);
    for (int i = 0; i < 10; i++) op(3'd0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 6) == 0), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg_n.md
# univ_shift_reg_n

Parametrised universal shift register with WIDTH bits. It supports hold, logical shifts, rotates, arithmetic shift right and parallel load. A burst engine performs a programmed number of shifts autonomously, with busy/done handshaking. The block is the general-purpose shift stage for serialisers, bit-manipulation datapaths and test sequences, and replaces fixed-width 4-bit universal registers.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- CNT_W, 4, burst count width; must satisfy 2^CNT_W > WIDTH.
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  clock enable; 0 freezes q, so_r, so_l and the burst counter.
- mode  input  3  operation select (see Operation).
- load_data  input  WIDTH  parallel load value.
- sir  input  1  serial input entering the MSB on logical shift right.
- sil  input  1  serial input entering the LSB on shift left.
- burst_start  input  1  request an autonomous burst using the current mode and burst_cnt.
- burst_cnt  input  CNT_W  number of shifts in the burst.
- q  output  WIDTH  register contents.
- so_r  output  1  last bit shifted out of the LSB on a right-type operation.
- so_l  output  1  last bit shifted out of the MSB on a left-type operation.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

## Operation
- Mode encoding:
  - 000 hold.
  - 001 logical shift right: q ← {sir, q[W-1:1]}.
  - 010 shift left: q ← {q[W-2:0], sil}.
  - 011 parallel load: q ← load_data.
  - 100 rotate right: q ← {q[0], q[W-1:1]}.
  - 101 rotate left: q ← {q[W-2:0], q[W-1]}.
  - 110 arithmetic shift right: q ← {q[W-1], q[W-1:1]}.
  - 111 reserved, behaves as hold.
- Right-type modes are 001, 100 and 110. On any such operation, so_r ← old q[0].
- Left-type modes are 010 and 101. On any such operation, so_l ← old q[W-1].
- so_r and so_l otherwise hold their values.
- FSM has two states, IDLE and RUN.
- IDLE, en=1, burst_start=0: the mode operation is applied every cycle.
- IDLE, burst_start=1: burst_start takes priority over mode, and q holds that cycle.
  - If the mode is a shift/rotate mode (001, 010, 100, 101, 110) and burst_cnt ≠ 0: capture mode and count, then go to RUN.
  - Otherwise: no state change, q unchanged, and done pulses on the next cycle.
- burst_start is honoured in IDLE regardless of en.
- RUN: each cycle with en=1 applies the captured operation once and decrements the count.
  - sir and sil are sampled live during the burst.
  - On the edge of the final shift: return to IDLE, busy ← 0, done ← 1 for one cycle.
- RUN, en=0: stall. Nothing changes and busy stays 1.
- In RUN, the mode, load_data and burst_start inputs are ignored.
- rst in any state, including mid-burst, sets:
  - q=0, so_r=0, so_l=0, busy=0, done=0
  - state IDLE, count 0

## Timing
- All outputs are registered. q reflects an operation in the cycle after the edge at which it was sampled.
- Reset values: q=0, so_r=0, so_l=0, busy=0, done=0.
- Burst of N shifts with en held at 1:
  - burst_start is sampled at edge E0.
  - busy is high after E0 through edge E0+N.
  - Shifts occur at edges E0+1 … E0+N.
  - done is high for the one cycle following E0+N; busy is low in that same cycle.
- Each en=0 cycle during RUN extends busy by one cycle.
- Degenerate or invalid burst: done is high for the single cycle after the sampling edge, and busy never asserts.
- A new burst_start is accepted in the done cycle, which is the cycle following E0+N, since the FSM is already IDLE.

## Test plan
- Reset: assert rst for 2 cycles with arbitrary inputs, so that q=0x00, so_r=0, so_l=0, busy=0 and done=0.
- Shift sequence (WIDTH=8):
  - Load 0xA5 (mode 011), giving q=0xA5.
  - Mode 001 with sir=1 gives q=0xD2 and so_r=1.
  - Mode 010 with sil=0 gives q=0xA4 and so_l=1.
- Rotates and arithmetic shift:
  - q=0x81 with mode 100 gives 0xC0.
  - q=0x81 with mode 101 gives 0x03.
  - q=0x80 with mode 110 gives 0xC0.
  - mode 111 holds q.
- Burst: q=0x0F, burst_start with mode 101 and cnt 4, en=1. busy stays high for 4 cycles. At completion q=0xF0 and done pulses once.
- Burst under stall and illegal requests: repeat the burst scenario with en=0 for 2 cycles mid-burst and a burst_start during RUN.
  - busy stays high for 6 cycles.
  - Final q=0xF0.
  - The second request is ignored.
- Degenerate cases and reset mid-burst:
  - cnt=0, or mode 011 with burst_start: done pulses next cycle, busy=0, q unchanged.
  - rst during RUN: next cycle q=0, busy=0, done=0, and no late done pulse.
